// File: rtl/imm_gen_stage_pkg.sv
// Shared constants for the immediate-generation stage: format codes, opcodes, skid states.
package imm_gen_stage_pkg;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Handshake bundle between fetch (master) and the immediate-generation stage (slave).
interface imm_gen_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_pc, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage_imm_decode_comb.sv
// Combinational RISC-V immediate decoder: instruction word -> {imm, fmt, illegal}.
module imm_decode_comb
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;
  logic [5:0] shamt;
  // Raw fields are built sign-extended to 32 bits; the signed size cast widens them to XLEN.
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // Bit 25 is only shamt on RV64; on RV32 it belongs to funct7 and must not leak in.
  assign shamt    = {(XLEN == 64) ? inst[25] : 1'b0, inst[24:20]};

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // Opcode-driven format selection; unknown opcodes fall through as illegal.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b1;
    case (opcode)
      OP_IMM: begin
        illegal = 1'b0;
        if (is_shift) begin
          fmt = FMT_Z;
          imm = XLEN'(shamt);
        end else begin
          fmt = FMT_I;
          imm = XLEN'(imm_i);
        end
      end
      LOAD, JALR: begin
        illegal = 1'b0;
        fmt     = FMT_I;
        imm     = XLEN'(imm_i);
      end
      SYSTEM: begin
        illegal = 1'b0;
        if (funct3[2]) begin
          fmt = FMT_Z;
          imm = XLEN'(inst[19:15]);
        end else begin
          fmt = FMT_I;
          imm = XLEN'(imm_i);
        end
      end
      STORE: begin
        illegal = 1'b0;
        fmt     = FMT_S;
        imm     = XLEN'(imm_s);
      end
      BRANCH: begin
        illegal = 1'b0;
        fmt     = FMT_B;
        imm     = XLEN'(imm_b);
      end
      LUI, AUIPC: begin
        illegal = 1'b0;
        fmt     = FMT_U;
        imm     = XLEN'(imm_u);
      end
      JAL: begin
        illegal = 1'b0;
        fmt     = FMT_J;
        imm     = XLEN'(imm_j);
      end
      OP: begin
        illegal = 1'b0;
        fmt     = FMT_R;
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          illegal = 1'b0;
          if (is_shift) begin
            fmt = FMT_Z;
            imm = XLEN'(inst[24:20]);
          end else begin
            fmt = FMT_I;
            imm = XLEN'(imm_i);
          end
        end
      end
      OP_32: begin
        if (XLEN == 64) begin
          illegal = 1'b0;
          fmt     = FMT_R;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with valid/ready and optional 2-entry skid buffer.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SKID_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  imm_gen_stage_if.slave  bus
);

  // Entry layout: {imm, fmt, illegal, pc}.
  localparam int unsigned EW = 2 * XLEN + 4;
  localparam logic [EW-1:0] RstEntry = {{XLEN{1'b0}}, FMT_NONE, 1'b0, {XLEN{1'b0}}};

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [EW-1:0]   new_entry;
  logic [EW-1:0]   main_q, main_d, skid_q, skid_d;
  skid_state_e     st_q, st_d;
  logic            in_ready_q, in_ready_d;
  logic            accept;

  imm_decode_comb #(
    .XLEN (XLEN)
  ) u_dec (
    .inst    (bus.in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign new_entry = {dec_imm, dec_fmt, dec_illegal, bus.in_pc};

  // Without the skid buffer, in_ready is combinational so a pop and a push share one cycle.
  assign bus.in_ready = (SKID_EN != 0) ? in_ready_q : ((st_q == StEmpty) || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = (st_q != StEmpty);
  assign {bus.out_imm, bus.out_fmt, bus.out_illegal, bus.out_pc} = main_q;

  // Next-state: main register holds the head, skid holds the overflow entry.
  always_comb begin
    st_d   = st_q;
    main_d = main_q;
    skid_d = skid_q;
    case (st_q)
      StEmpty: begin
        if (accept) begin
          main_d = new_entry;
          st_d   = StOne;
        end
      end
      StOne: begin
        if (accept) begin
          if (bus.out_ready) begin
            main_d = new_entry;
          end else begin
            skid_d = new_entry;
            st_d   = StTwo;
          end
        end else if (bus.out_ready) begin
          st_d = StEmpty;
        end
      end
      StTwo: begin
        if (bus.out_ready) begin
          main_d = skid_q;
          st_d   = StOne;
        end
      end
      default: st_d = StEmpty;
    endcase
    if (flush) st_d = StEmpty;
    in_ready_d = (st_d != StTwo);
  end

  // State and data registers; reset discards every held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StEmpty;
      main_q     <= RstEntry;
      skid_q     <= RstEntry;
      in_ready_q <= 1'b1;
    end else begin
      st_q       <= st_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule
